// File: rtl/mouse_init_sequencer.sv
// PS/2 mouse initialisation and stream-mode packet decoder.
// Brings the mouse out of reset (FF, BAT, ID), sets the sample rate
// (F3 + SAMPLE_RATE), enables streaming (F4) and then assembles the
// three-byte movement packets.
// Optional build macro: MOUSE_INIT_OVF_SAT_EN -- saturate an axis delta
// to -256/+255 when that axis reports overflow (raw value otherwise).
module mouse_init_sequencer #(
    parameter int         TIMEOUT_CYCLES = 25_000_000,
    parameter int         RESYNC_CYCLES  = 100_000,
    parameter logic [7:0] SAMPLE_RATE    = 8'd100,
    parameter int         MAX_RETRIES    = 3
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_done,
    input  logic       tx_error,
    output logic       init_done,
    output logic       init_error,
    output logic       pkt_valid,
    output logic [2:0] pkt_buttons,
    output logic [8:0] pkt_dx,
    output logic [8:0] pkt_dy,
    output logic [1:0] pkt_ovf
);

    typedef enum logic [2:0] {
        SEND_RST,
        WAIT_ACK,
        WAIT_BAT,
        WAIT_ID,
        SEND_CMD,
        STREAM,
        ERROR
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] RESYNC_LIMIT = 32'(RESYNC_CYCLES);

    state_t      state;
    logic [1:0]  cmd_idx;
    logic [7:0]  retry_cnt;
    logic [31:0] wait_cnt;
    logic        sent;

    logic [1:0]  byte_idx;
    logic [31:0] gap_cnt;
    logic [3:0]  b0_flags;
    logic [2:0]  b0_btn;
    logic [7:0]  b1;

    logic        fail;
    logic        timeout_hit;
    logic        retries_exhausted;
    logic [8:0]  dx_next;
    logic [8:0]  dy_next;

    // Byte sent for each step of the init command list.
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'hFF;
            2'd1:    return 8'hF3;
            2'd2:    return SAMPLE_RATE;
            default: return 8'hF4;
        endcase
    endfunction

    // Failure detection; a received byte always wins over a simultaneous timeout.
    always_comb begin
        fail              = 1'b0;
        timeout_hit       = (wait_cnt == TIMEOUT_LAST);
        retries_exhausted = (({24'd0, retry_cnt} + 32'd1) >= 32'(MAX_RETRIES));
        case (state)
            SEND_RST, SEND_CMD: fail = tx_error;
            WAIT_ACK: begin
                if (rx_valid)
                    fail = (rx_data != 8'hFA) && (rx_data != 8'hFE);
                else
                    fail = timeout_hit;
            end
            WAIT_BAT: begin
                if (rx_valid)
                    fail = (rx_data != 8'hAA);
                else
                    fail = timeout_hit;
            end
            WAIT_ID: begin
                if (rx_valid)
                    fail = (rx_data != 8'h00);
                else
                    fail = timeout_hit;
            end
            default: fail = 1'b0;
        endcase
    end

    // Packet deltas from the latched first/second byte and the incoming third byte.
    always_comb begin
        dx_next = {b0_flags[0], b1};
        dy_next = {b0_flags[1], rx_data};
`ifdef MOUSE_INIT_OVF_SAT_EN
        if (b0_flags[2])
            dx_next = b0_flags[0] ? 9'h100 : 9'h0FF;
        if (b0_flags[3])
            dy_next = b0_flags[1] ? 9'h100 : 9'h0FF;
`endif
    end

    // Init sequencer, retry handling and stream packet assembly.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= SEND_RST;
            cmd_idx     <= 2'd0;
            retry_cnt   <= 8'd0;
            wait_cnt    <= 32'd0;
            sent        <= 1'b0;
            byte_idx    <= 2'd0;
            gap_cnt     <= 32'd0;
            b0_flags    <= 4'd0;
            b0_btn      <= 3'd0;
            b1          <= 8'd0;
            tx_data     <= 8'hFF;
            tx_send     <= 1'b0;
            init_done   <= 1'b0;
            init_error  <= 1'b0;
            pkt_valid   <= 1'b0;
            pkt_buttons <= 3'd0;
            pkt_dx      <= 9'd0;
            pkt_dy      <= 9'd0;
            pkt_ovf     <= 2'd0;
        end else begin
            tx_send   <= 1'b0;
            pkt_valid <= 1'b0;
            if (fail) begin
                retry_cnt <= retry_cnt + 8'd1;
                wait_cnt  <= 32'd0;
                sent      <= 1'b0;
                if (retries_exhausted) begin
                    state      <= ERROR;
                    init_error <= 1'b1;
                end else begin
                    state   <= SEND_RST;
                    cmd_idx <= 2'd0;
                end
            end else begin
                case (state)
                    SEND_RST, SEND_CMD: begin
                        if (!sent) begin
                            tx_send <= 1'b1;
                            tx_data <= cmd_byte(cmd_idx);
                            sent    <= 1'b1;
                        end else if (tx_done) begin
                            state    <= WAIT_ACK;
                            wait_cnt <= 32'd0;
                            sent     <= 1'b0;
                        end
                    end
                    WAIT_ACK: begin
                        if (rx_valid) begin
                            wait_cnt <= 32'd0;
                            if (rx_data == 8'hFA) begin
                                if (cmd_idx == 2'd0) begin
                                    state <= WAIT_BAT;
                                end else if (cmd_idx == 2'd3) begin
                                    state     <= STREAM;
                                    init_done <= 1'b1;
                                    byte_idx  <= 2'd0;
                                    gap_cnt   <= 32'd0;
                                end else begin
                                    state   <= SEND_CMD;
                                    cmd_idx <= cmd_idx + 2'd1;
                                end
                            end else begin
                                state <= (cmd_idx == 2'd0) ? SEND_RST : SEND_CMD;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 32'd1;
                        end
                    end
                    WAIT_BAT: begin
                        if (rx_valid) begin
                            state    <= WAIT_ID;
                            wait_cnt <= 32'd0;
                        end else begin
                            wait_cnt <= wait_cnt + 32'd1;
                        end
                    end
                    WAIT_ID: begin
                        if (rx_valid) begin
                            state    <= SEND_CMD;
                            cmd_idx  <= 2'd1;
                            wait_cnt <= 32'd0;
                        end else begin
                            wait_cnt <= wait_cnt + 32'd1;
                        end
                    end
                    STREAM: begin
                        if (rx_valid) begin
                            gap_cnt <= 32'd0;
                            case (byte_idx)
                                2'd0: begin
                                    if (rx_data[3]) begin
                                        b0_flags <= rx_data[7:4];
                                        b0_btn   <= rx_data[2:0];
                                        byte_idx <= 2'd1;
                                    end
                                end
                                2'd1: begin
                                    b1       <= rx_data;
                                    byte_idx <= 2'd2;
                                end
                                default: begin
                                    pkt_buttons <= b0_btn;
                                    pkt_dx      <= dx_next;
                                    pkt_dy      <= dy_next;
                                    pkt_ovf     <= b0_flags[3:2];
                                    pkt_valid   <= 1'b1;
                                    byte_idx    <= 2'd0;
                                end
                            endcase
                        end else if (byte_idx != 2'd0) begin
                            if (gap_cnt == RESYNC_LIMIT) begin
                                byte_idx <= 2'd0;
                                gap_cnt  <= 32'd0;
                            end else begin
                                gap_cnt <= gap_cnt + 32'd1;
                            end
                        end
                    end
                    ERROR: begin
                        init_error <= 1'b1;
                    end
                    default: begin
                        state <= SEND_RST;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mouse_init_sequencer.sv
// Directed testbench for mouse_init_sequencer: init handshake, resend,
// transmit error, timeout to error, and stream packet decoding.
module tb_mouse_init_sequencer;

    localparam int TB_TIMEOUT = 100;
    localparam int TB_RESYNC  = 20;

    logic       CLOCK_50;
    logic       resetn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_done;
    logic       tx_error;
    logic       init_done;
    logic       init_error;
    logic       pkt_valid;
    logic [2:0] pkt_buttons;
    logic [8:0] pkt_dx;
    logic [8:0] pkt_dy;
    logic [1:0] pkt_ovf;

    int passCount  = 0;
    int checkCount = 0;
    int txCount    = 0;

    mouse_init_sequencer #(
        .TIMEOUT_CYCLES(TB_TIMEOUT),
        .RESYNC_CYCLES (TB_RESYNC),
        .SAMPLE_RATE   (8'd100),
        .MAX_RETRIES   (3)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .init_done  (init_done),
        .init_error (init_error),
        .pkt_valid  (pkt_valid),
        .pkt_buttons(pkt_buttons),
        .pkt_dx     (pkt_dx),
        .pkt_dy     (pkt_dy),
        .pkt_ovf    (pkt_ovf)
    );

    // 50 MHz clock.
    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Running count of transmit requests seen at the active edge.
    always @(posedge CLOCK_50) begin
        if (tx_send === 1'b1)
            txCount <= txCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLOCK_50);
        rx_valid = 1'b0;
    endtask

    task automatic applyReset();
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_done  = 1'b0;
        tx_error = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    task automatic pulseDone();
        tx_done = 1'b1;
        @(negedge CLOCK_50);
        tx_done = 1'b0;
    endtask

    task automatic waitTx(input string tag, input logic [7:0] expByte);
        int n = 0;
        while (tx_send !== 1'b1 && n < 400) begin
            @(negedge CLOCK_50);
            n++;
        end
        checkOutput({tag, "_send"}, {31'd0, tx_send}, 32'd1);
        checkOutput({tag, "_data"}, {24'd0, tx_data}, {24'd0, expByte});
    endtask

    task automatic serveTx(input string tag, input logic [7:0] expByte, input logic [7:0] resp);
        waitTx(tag, expByte);
        @(negedge CLOCK_50);
        checkOutput({tag, "_pulse"}, {31'd0, tx_send}, 32'd0);
        pulseDone();
        applyStimulus(resp);
    endtask

    initial begin
        int txBase;
        int n;

        $display("[TB] start");
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_done  = 1'b0;
        tx_error = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("rst_tx_data", {24'd0, tx_data}, 32'h0FF);
        checkOutput("rst_tx_send", {31'd0, tx_send}, 32'd0);
        checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
        checkOutput("rst_init_error", {31'd0, init_error}, 32'd0);
        checkOutput("rst_pkt", {11'd0, pkt_valid, pkt_buttons, pkt_ovf, pkt_dx, pkt_dy}, 32'd0);

        // Normal init: FF, BAT, ID, F3, rate, F4.
        applyReset();
        @(negedge CLOCK_50);
        checkOutput("first_edge_send", {31'd0, tx_send}, 32'd1);
        serveTx("n_ff", 8'hFF, 8'hFA);
        applyStimulus(8'hAA);
        applyStimulus(8'h00);
        serveTx("n_f3", 8'hF3, 8'hFA);
        serveTx("n_rate", 8'h64, 8'hFA);
        checkOutput("n_not_done_yet", {31'd0, init_done}, 32'd0);
        serveTx("n_f4", 8'hF4, 8'hFA);
        checkOutput("n_init_done", {31'd0, init_done}, 32'd1);
        checkOutput("n_retry", {24'd0, dut.retry_cnt}, 32'd0);

        // Stream: 0x01 has bit3 clear and is dropped; 09,05,FB is the packet.
        txBase = txCount;
        applyStimulus(8'h01);
        applyStimulus(8'h09);
        applyStimulus(8'h05);
        checkOutput("resync_nopkt", {31'd0, pkt_valid}, 32'd0);
        applyStimulus(8'hFB);
        checkOutput("resync_valid", {31'd0, pkt_valid}, 32'd1);
        checkOutput("resync_btn", {29'd0, pkt_buttons}, 32'd1);
        checkOutput("resync_dx", {23'd0, pkt_dx}, 32'h005);
        // byte0 bit5 clear: dy sign positive, 0x0FB
        checkOutput("resync_dy", {23'd0, pkt_dy}, 32'h0FB);
        @(negedge CLOCK_50);
        checkOutput("resync_one_pulse", {31'd0, pkt_valid}, 32'd0);
        repeat (3) @(negedge CLOCK_50);
        checkOutput("hold_dx", {23'd0, pkt_dx}, 32'h005);

        // Negative y: byte0 0x29 sets the y sign bit, dy = -5.
        applyStimulus(8'h29);
        applyStimulus(8'h05);
        applyStimulus(8'hFB);
        checkOutput("neg_valid", {31'd0, pkt_valid}, 32'd1);
        checkOutput("neg_dy", {23'd0, pkt_dy}, 32'h1FB);

        // Gap longer than the resync limit drops the partial packet.
        applyStimulus(8'h08);
        applyStimulus(8'h10);
        repeat (TB_RESYNC + 1) @(negedge CLOCK_50);
        applyStimulus(8'h08);
        checkOutput("gap_nopkt", {31'd0, pkt_valid}, 32'd0);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        checkOutput("gap_valid", {31'd0, pkt_valid}, 32'd1);
        checkOutput("gap_dx", {23'd0, pkt_dx}, 32'h001);
        checkOutput("gap_dy", {23'd0, pkt_dy}, 32'h002);

        // X overflow with x sign set.
        applyStimulus(8'h58);
        applyStimulus(8'h10);
        applyStimulus(8'h00);
        checkOutput("ovf_valid", {31'd0, pkt_valid}, 32'd1);
`ifdef MOUSE_INIT_OVF_SAT_EN
        checkOutput("ovf_dx", {23'd0, pkt_dx}, 32'h100);
`else
        checkOutput("ovf_dx", {23'd0, pkt_dx}, 32'h110);
`endif
        checkOutput("ovf_bits", {30'd0, pkt_ovf}, 32'd1);
        checkOutput("ovf_dy", {23'd0, pkt_dy}, 32'h000);
        checkOutput("stream_no_tx", txCount - txBase, 32'd0);

        // Resend: FE after F3 repeats F3 without a retry.
        applyReset();
        serveTx("r_ff", 8'hFF, 8'hFA);
        applyStimulus(8'hAA);
        applyStimulus(8'h00);
        serveTx("r_f3", 8'hF3, 8'hFE);
        serveTx("r_f3_again", 8'hF3, 8'hFA);
        serveTx("r_rate", 8'h64, 8'hFA);
        serveTx("r_f4", 8'hF4, 8'hFA);
        checkOutput("r_init_done", {31'd0, init_done}, 32'd1);
        checkOutput("r_retry", {24'd0, dut.retry_cnt}, 32'd0);

        // Transmit error counts as a failure and restarts with FF.
        applyReset();
        waitTx("e_ff", 8'hFF);
        tx_error = 1'b1;
        @(negedge CLOCK_50);
        tx_error = 1'b0;
        waitTx("e_ff_retry", 8'hFF);
        checkOutput("e_retry", {24'd0, dut.retry_cnt}, 32'd1);

        // Silent device: three FF attempts, then the error state.
        applyReset();
        for (int a = 0; a < 3; a++) begin
            waitTx($sformatf("t_ff%0d", a), 8'hFF);
            @(negedge CLOCK_50);
            pulseDone();
        end
        n = 0;
        while (init_error !== 1'b1 && n < 400) begin
            @(negedge CLOCK_50);
            n++;
        end
        checkOutput("t_init_error", {31'd0, init_error}, 32'd1);
        checkOutput("t_init_done", {31'd0, init_done}, 32'd0);
        txBase = txCount;
        repeat (300) @(negedge CLOCK_50);
        checkOutput("t_no_tx", txCount - txBase, 32'd0);
        checkOutput("t_error_hold", {31'd0, init_error}, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
